// File: rtl/neurosync_param.sv
// neurosync_param: memory-sequence game core.
// Grows a pseudo-random sequence, shows it on N_CH LEDs and checks the
// player's reproduction on N_CH buttons. Entry can be forward or reverse, and
// each press has its own timeout. The game ends in win, error or timeout.
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-high
//   jogar      start/restart request (honoured in INICIAL and terminal states)
//   nivel      0: MAX_ROUNDS/2 rounds, 1: MAX_ROUNDS rounds (latched at start)
//   modo       0: forward entry, 1: reverse entry (latched at start)
//   botoes     debounced synchronous buttons, active-high
//   leds       one-hot shown element, or echo of botoes while awaiting a press
//   rodada     current sequence length
//   pronto     game finished
//   ganhou     finished by completing all rounds
//   errou      finished by a wrong or invalid press
//   timeout    finished by a press timeout
//   db_estado  FSM state code
module neurosync_param #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned MAX_ROUNDS     = 16,
    parameter int unsigned SHOW_CYCLES    = 1000,
    parameter int unsigned GAP_CYCLES     = 500,
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              jogar,
    input  logic                              nivel,
    input  logic                              modo,
    input  logic [N_CH-1:0]                   botoes,
    output logic [N_CH-1:0]                   leds,
    output logic [$clog2(MAX_ROUNDS+1)-1:0]   rodada,
    output logic                              pronto,
    output logic                              ganhou,
    output logic                              errou,
    output logic                              timeout,
    output logic [3:0]                        db_estado
);

    localparam int unsigned W     = (N_CH > 2) ? $clog2(N_CH) : 1;
    localparam int unsigned RW    = $clog2(MAX_ROUNDS + 1);
    localparam int unsigned IW    = (MAX_ROUNDS > 2) ? $clog2(MAX_ROUNDS) : 1;
    localparam int unsigned T_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned T_MAX = (T_SG > TIMEOUT_CYCLES) ? T_SG : TIMEOUT_CYCLES;
    localparam int unsigned TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [3:0] {
        S_INICIAL     = 4'd0,
        S_PREPARA     = 4'd1,
        S_NOVO_ELEM   = 4'd2,
        S_MOSTRA_ON   = 4'd3,
        S_MOSTRA_OFF  = 4'd4,
        S_ESPERA      = 4'd5,
        S_COMPARA     = 4'd6,
        S_FIM_RODADA  = 4'd7,
        S_FIM_GANHOU  = 4'd8,
        S_FIM_ERRO    = 4'd9,
        S_FIM_TIMEOUT = 4'd10
    } state_t;

    // Index of the highest set bit; only meaningful for one-hot input.
    function automatic logic [W-1:0] onehot_index(input logic [N_CH-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [RW-1:0]   rodada_n;
    logic [RW-1:0]   target, target_n;
    logic            modo_q, modo_n;
    logic [IW-1:0]   idx, idx_n;          // element being shown
    logic [IW-1:0]   ent, ent_n;          // element expected from the player
    logic [W-1:0]    press_idx, press_idx_n;
    logic            press_ok, press_ok_n;
    logic [N_CH-1:0] prev_btn;
    logic [15:0]     lfsr;
    logic [N_CH-1:0] leds_n;
    logic            pronto_n, ganhou_n, errou_n, timeout_n;

    logic [W-1:0]    mem [MAX_ROUNDS];
    logic            mem_we;
    logic [W-1:0]    new_elem;
    logic [W-1:0]    show_elem;
    logic            press_c;
    logic            last_shown;
    logic            entry_last;

    assign new_elem   = W'(lfsr % 16'(N_CH));
    assign press_c    = (botoes != '0) && (prev_btn == '0);
    assign last_shown = (RW'(idx) == rodada - RW'(1));
    assign entry_last = modo_q ? (ent == '0) : (RW'(ent) == rodada - RW'(1));
    assign db_estado  = state;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        rodada_n    = rodada;
        target_n    = target;
        modo_n      = modo_q;
        idx_n       = idx;
        ent_n       = ent;
        press_idx_n = press_idx;
        press_ok_n  = press_ok;
        mem_we      = 1'b0;
        leds_n      = '0;
        show_elem   = '0;

        case (state)
            S_INICIAL: begin
                if (jogar) begin
                    state_n  = S_PREPARA;
                    rodada_n = '0;
                end
            end
            S_PREPARA: begin
                rodada_n = '0;
                modo_n   = modo;
                target_n = nivel ? RW'(MAX_ROUNDS) : RW'(MAX_ROUNDS / 2);
                state_n  = S_NOVO_ELEM;
            end
            S_NOVO_ELEM: begin
                mem_we   = 1'b1;
                rodada_n = rodada + RW'(1);
                idx_n    = '0;
                timer_n  = '0;
                state_n  = S_MOSTRA_ON;
            end
            S_MOSTRA_ON: begin
                if (timer == TW'(SHOW_CYCLES - 1)) begin
                    timer_n = '0;
                    state_n = S_MOSTRA_OFF;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_MOSTRA_OFF: begin
                if (timer == TW'(GAP_CYCLES - 1)) begin
                    timer_n = '0;
                    if (last_shown) begin
                        state_n = S_ESPERA;
                        ent_n   = modo_q ? IW'(rodada - RW'(1)) : '0;
                    end else begin
                        idx_n   = idx + IW'(1);
                        state_n = S_MOSTRA_ON;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_ESPERA: begin
                // A press in the last timer cycle still wins over the timeout.
                if (press_c) begin
                    press_idx_n = onehot_index(botoes);
                    press_ok_n  = $onehot(botoes);
                    state_n     = S_COMPARA;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = S_FIM_TIMEOUT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_COMPARA: begin
                if (!press_ok || (press_idx != mem[ent])) begin
                    state_n = S_FIM_ERRO;
                end else if (entry_last) begin
                    state_n = S_FIM_RODADA;
                end else begin
                    ent_n   = modo_q ? (ent - IW'(1)) : (ent + IW'(1));
                    timer_n = '0;
                    state_n = S_ESPERA;
                end
            end
            S_FIM_RODADA: begin
                state_n = (rodada == target) ? S_FIM_GANHOU : S_NOVO_ELEM;
            end
            S_FIM_GANHOU, S_FIM_ERRO, S_FIM_TIMEOUT: begin
                if (jogar) begin
                    state_n  = S_PREPARA;
                    rodada_n = '0;
                end
            end
            default: begin
                state_n = S_INICIAL;
            end
        endcase

        // The element just written in NOVO_ELEM is shown first in round one,
        // so bypass the memory when the read hits the write address.
        if (mem_we && (IW'(rodada) == idx_n)) begin
            show_elem = new_elem;
        end else begin
            show_elem = mem[idx_n];
        end

        case (state_n)
            S_MOSTRA_ON: leds_n = N_CH'(1) << show_elem;
            S_ESPERA:    leds_n = botoes;
            default:     leds_n = '0;
        endcase

        ganhou_n  = (state_n == S_FIM_GANHOU);
        errou_n   = (state_n == S_FIM_ERRO);
        timeout_n = (state_n == S_FIM_TIMEOUT);
        pronto_n  = ganhou_n || errou_n || timeout_n;
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_INICIAL;
            timer     <= '0;
            rodada    <= '0;
            target    <= '0;
            modo_q    <= 1'b0;
            idx       <= '0;
            ent       <= '0;
            press_idx <= '0;
            press_ok  <= 1'b0;
            prev_btn  <= '0;
            lfsr      <= LFSR_SEED;
            leds      <= '0;
            pronto    <= 1'b0;
            ganhou    <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            rodada    <= rodada_n;
            target    <= target_n;
            modo_q    <= modo_n;
            idx       <= idx_n;
            ent       <= ent_n;
            press_idx <= press_idx_n;
            press_ok  <= press_ok_n;
            prev_btn  <= botoes;
            lfsr      <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
            leds      <= leds_n;
            pronto    <= pronto_n;
            ganhou    <= ganhou_n;
            errou     <= errou_n;
            timeout   <= timeout_n;
        end
    end

    // Sequence memory; no reset, only entries below rodada are ever read.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[IW'(rodada)] <= new_elem;
        end
    end

endmodule
